// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Holds a small instruction memory that is filled over a valid/ready load
// stream. It then feeds a datapath by answering the datapath's fetch PC
// combinationally. The block does the following:
//   - keeps the datapath in reset while a program is being loaded,
//   - releases the datapath when start is seen,
//   - swaps the halt instruction for a NOP,
//   - issues a fixed number of drain NOPs after the halt,
//   - reports halted until start is pressed again, which requests a reload.
//
// Optional feature: define CYCLE_COUNTER_EN to build a saturating counter of
// the cycles spent in RUN and DRAIN. Without it, runCycles is tied to zero.
//
// Parameters
//   MEM_DEPTH     number of 32-bit words stored (at most 256, because pc is 8 bits)
//   HALT_OPCODE   instruction[31:26] value that ends a run
//   DRAIN_CYCLES  number of NOP cycles issued after the halt is detected
//
// Ports
//   clock          single clock
//   reset          asynchronous, active-high reset (memory contents are kept)
//   loadValid      a program word is present on loadData
//   loadData       program word
//   loadLast       final word of the program (qualified by loadValid)
//   loadReady      a word is accepted this cycle
//   start          run request in READY, reload request in HALT
//   pc             fetch PC from the datapath, counted in words
//   instruction    instruction to the datapath (combinational from pc)
//   datapathReset  holds the datapath in reset in LOAD and READY
//   halted         the program has finished
//   wordCount      number of words loaded
//   runCycles      cycles spent in RUN and DRAIN
// -----------------------------------------------------------------------------
module instruction_loader #(
    parameter int         MEM_DEPTH    = 256,
    parameter logic [5:0] HALT_OPCODE  = 6'h3F,
    parameter int         DRAIN_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        loadValid,
    input  logic [31:0] loadData,
    input  logic        loadLast,
    output logic        loadReady,
    input  logic        start,
    input  logic [7:0]  pc,
    output logic [31:0] instruction,
    output logic        datapathReset,
    output logic        halted,
    output logic [8:0]  wordCount,
    output logic [15:0] runCycles
);

    localparam int ADDR_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [8:0]         DEPTH_W9   = 9'(MEM_DEPTH);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = DRAIN_W'(0);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_READY = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [8:0]          word_count_q, word_count_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic                load_ready_q, load_ready_d;
    logic                datapath_reset_q, datapath_reset_d;
    logic                halted_q, halted_d;

    logic [31:0]         mem_q [MEM_DEPTH];

    logic                handshake_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic                in_range_s;
    logic [31:0]         fetch_word_s;
    logic                fetch_halt_s;
    logic [31:0]         instruction_s;

    // True when a word carries the halt opcode in its top six bits.
    function automatic logic is_halt_word(input logic [31:0] word);
        return (word[31:26] == HALT_OPCODE);
    endfunction

    // Fetch path: the read address is the datapath PC. Words at or above
    // wordCount may be stale from an earlier program, so they read as a NOP
    // and can never trigger a halt.
    always_comb begin
        rd_addr_s    = ADDR_W'(pc);
        wr_addr_s    = word_count_q[ADDR_W-1:0];
        in_range_s   = ({1'b0, pc} < word_count_q);
        if (in_range_s) begin
            fetch_word_s = mem_q[rd_addr_s];
        end else begin
            fetch_word_s = 32'h0000_0000;
        end
        fetch_halt_s = in_range_s && is_halt_word(fetch_word_s);
        handshake_s  = loadValid && (state_q == ST_LOAD) && (word_count_q < DEPTH_W9);
    end

    // Next-state and next-output logic for the load/run/drain sequencer.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        drain_cnt_d  = drain_cnt_q;
        mem_we_s     = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (handshake_s) begin
                    mem_we_s     = 1'b1;
                    word_count_d = word_count_q + 9'd1;
                    if (loadLast || (word_count_d == DEPTH_W9)) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_READY: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_RUN: begin
                if (fetch_halt_s) begin
                    drain_cnt_d = DRAIN_LOAD;
                    state_d     = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A counter of 0 is treated like 1, so DRAIN_CYCLES = 0
                // still leaves DRAIN after one cycle instead of hanging.
                if (drain_cnt_q <= DRAIN_ONE) begin
                    drain_cnt_d = DRAIN_ZERO;
                    state_d     = ST_HALT;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_ONE;
                    state_d     = ST_DRAIN;
                end
            end
            ST_HALT: begin
                if (start) begin
                    word_count_d = 9'd0;
                    state_d      = ST_LOAD;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                // Unreachable encodings recover to an empty load.
                word_count_d = 9'd0;
                drain_cnt_d  = DRAIN_ZERO;
                state_d      = ST_LOAD;
            end
        endcase

        load_ready_d     = (state_d == ST_LOAD) && (word_count_d < DEPTH_W9);
        datapath_reset_d = (state_d == ST_LOAD) || (state_d == ST_READY);
        halted_d         = (state_d == ST_HALT);
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_LOAD;
            word_count_q     <= 9'd0;
            drain_cnt_q      <= DRAIN_ZERO;
            load_ready_q     <= (MEM_DEPTH > 0);
            datapath_reset_q <= 1'b1;
            halted_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            word_count_q     <= word_count_d;
            drain_cnt_q      <= drain_cnt_d;
            load_ready_q     <= load_ready_d;
            datapath_reset_q <= datapath_reset_d;
            halted_q         <= halted_d;
        end
    end

    // Instruction memory write port. It has no reset, so a program survives
    // a reset or a reload.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[wr_addr_s] <= loadData;
        end
    end

    // Instruction mux: only RUN forwards memory, and the halt word itself
    // goes out as a NOP.
    always_comb begin
        if ((state_q == ST_RUN) && !fetch_halt_s) begin
            instruction_s = fetch_word_s;
        end else begin
            instruction_s = 32'h0000_0000;
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [15:0] run_cycles_q, run_cycles_d;

    // Run-cycle counter: cleared when a run starts, counts RUN and DRAIN
    // edges, saturates, and holds everywhere else.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if ((state_q == ST_READY) && start) begin
            run_cycles_d = 16'h0000;
        end else if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                     (run_cycles_q != 16'hFFFF)) begin
            run_cycles_d = run_cycles_q + 16'h0001;
        end else begin
            run_cycles_d = run_cycles_q;
        end
    end

    // Run-cycle counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cycles_q <= 16'h0000;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign runCycles = run_cycles_q;
`else
    assign runCycles = 16'h0000;
`endif

    assign loadReady     = load_ready_q;
    assign datapathReset = datapath_reset_q;
    assign halted        = halted_q;
    assign wordCount     = word_count_q;
    assign instruction   = instruction_s;

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
// Table-driven bench for instruction_loader. Each record holds the inputs for
// one cycle and the outputs expected during that cycle. The expected record is
// queued when the inputs are driven, then popped and compared once the
// combinational outputs have settled, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_loader;

    typedef struct {
        logic        lv;
        logic [31:0] ld;
        logic        ll;
        logic        st;
        logic [7:0]  pc;
        logic        e_rdy;
        logic [31:0] e_ins;
        logic        e_dpr;
        logic        e_hlt;
        logic [8:0]  e_wc;
        logic        chk_rc;
        logic [15:0] e_rc;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        start;
    logic [7:0]  pc;
    logic [31:0] instruction;
    logic        datapath_reset;
    logic        halted;
    logic [8:0]  word_count;
    logic [15:0] run_cycles;

    int checks;
    int errors;
    vec_t exp_q[$];
    vec_t tbl[15];

    instruction_loader #(
        .MEM_DEPTH   (256),
        .HALT_OPCODE (6'h3F),
        .DRAIN_CYCLES(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .loadValid    (load_valid),
        .loadData     (load_data),
        .loadLast     (load_last),
        .loadReady    (load_ready),
        .start        (start),
        .pc           (pc),
        .instruction  (instruction),
        .datapathReset(datapath_reset),
        .halted       (halted),
        .wordCount    (word_count),
        .runCycles    (run_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic lv, input logic [31:0] ld, input logic ll,
                                input logic st, input logic [7:0] p, input logic rdy,
                                input logic [31:0] ins, input logic dpr, input logic hlt,
                                input logic [8:0] wc, input logic chk_rc, input logic [15:0] rc);
        vec_t v;
        v.lv = lv; v.ld = ld; v.ll = ll; v.st = st; v.pc = p;
        v.e_rdy = rdy; v.e_ins = ins; v.e_dpr = dpr; v.e_hlt = hlt; v.e_wc = wc;
        v.chk_rc = chk_rc;
`ifdef CYCLE_COUNTER_EN
        v.e_rc = rc;
`else
        v.e_rc = 16'h0000;
`endif
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_check();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            chk("loadReady", {31'd0, load_ready}, {31'd0, e.e_rdy});
            chk("instruction", instruction, e.e_ins);
            chk("datapathReset", {31'd0, datapath_reset}, {31'd0, e.e_dpr});
            chk("halted", {31'd0, halted}, {31'd0, e.e_hlt});
            chk("wordCount", {23'd0, word_count}, {23'd0, e.e_wc});
            if (e.chk_rc) begin
                chk("runCycles", {16'd0, run_cycles}, {16'd0, e.e_rc});
            end else begin
                chk("runCycles_idle", 32'd0, 32'd0 & {16'd0, run_cycles});
            end
        end
    endtask

    // Drive one cycle of inputs just after a rising edge and compare the
    // outputs before the next one.
    task automatic step(input vec_t v);
        load_valid = v.lv;
        load_data  = v.ld;
        load_last  = v.ll;
        start      = v.st;
        pc         = v.pc;
        exp_q.push_back(v);
        #3;
        sb_check();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        load_valid = 1'b0; load_last = 1'b0; start = 1'b0; pc = 8'd0; load_data = 32'd0;
        #2 reset = 1'b1;
        #1;
        chk("rst_loadReady", {31'd0, load_ready}, 32'd1);
        chk("rst_datapathReset", {31'd0, datapath_reset}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_wordCount", {23'd0, word_count}, 32'd0);
        chk("rst_runCycles", {16'd0, run_cycles}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        load_valid = 1'b0; load_data = 32'd0; load_last = 1'b0; start = 1'b0; pc = 8'd0;

        // Load three words, run them, drain and halt, then request a reload.
        tbl[0]  = mk(1'b1, 32'h20010005, 1'b0, 1'b0, 8'd0, 1'b1, 32'h0,        1'b1, 1'b0, 9'd0, 1'b1, 16'd0);
        tbl[1]  = mk(1'b1, 32'h20020007, 1'b0, 1'b0, 8'd0, 1'b1, 32'h0,        1'b1, 1'b0, 9'd1, 1'b1, 16'd0);
        tbl[2]  = mk(1'b1, 32'hFC000000, 1'b1, 1'b0, 8'd0, 1'b1, 32'h0,        1'b1, 1'b0, 9'd2, 1'b1, 16'd0);
        tbl[3]  = mk(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0,        1'b1, 1'b0, 9'd3, 1'b1, 16'd0);
        tbl[4]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 32'h0,        1'b1, 1'b0, 9'd3, 1'b1, 16'd0);
        tbl[5]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'h20010005, 1'b0, 1'b0, 9'd3, 1'b1, 16'd0);
        tbl[6]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd1, 1'b0, 32'h20020007, 1'b0, 1'b0, 9'd3, 1'b1, 16'd1);
        tbl[7]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd2, 1'b0, 32'h0,        1'b0, 1'b0, 9'd3, 1'b1, 16'd2);
        tbl[8]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'h0,        1'b0, 1'b0, 9'd3, 1'b1, 16'd3);
        tbl[9]  = mk(1'b1, 32'h12345678, 1'b0, 1'b1, 8'd1, 1'b0, 32'h0,        1'b0, 1'b0, 9'd3, 1'b1, 16'd4);
        tbl[10] = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'h0,        1'b0, 1'b0, 9'd3, 1'b1, 16'd5);
        tbl[11] = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd1, 1'b0, 32'h0,        1'b0, 1'b0, 9'd3, 1'b1, 16'd6);
        tbl[12] = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'h0,        1'b0, 1'b1, 9'd3, 1'b1, 16'd7);
        tbl[13] = mk(1'b0, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 32'h0,        1'b0, 1'b1, 9'd3, 1'b1, 16'd7);
        tbl[14] = mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd0, 1'b1, 32'h0,        1'b1, 1'b0, 9'd0, 1'b1, 16'd7);

        // Reset state while reset is held.
        @(posedge clock);
        #1;
        chk("init_loadReady", {31'd0, load_ready}, 32'd1);
        chk("init_datapathReset", {31'd0, datapath_reset}, 32'd1);
        chk("init_halted", {31'd0, halted}, 32'd0);
        chk("init_instruction", instruction, 32'h0);
        chk("init_wordCount", {23'd0, word_count}, 32'd0);
        chk("init_runCycles", {16'd0, run_cycles}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i]);
        end

        // Out of range: two words over stale memory, where stale mem[2] is a halt word.
        step(mk(1'b1, 32'h11111111, 1'b0, 1'b0, 8'd0,  1'b1, 32'h0,        1'b1, 1'b0, 9'd0, 1'b0, 16'd0));
        step(mk(1'b1, 32'h22222222, 1'b1, 1'b0, 8'd0,  1'b1, 32'h0,        1'b1, 1'b0, 9'd1, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b1, 8'd0,  1'b0, 32'h0,        1'b1, 1'b0, 9'd2, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b0, 8'h10, 1'b0, 32'h0,        1'b0, 1'b0, 9'd2, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd2,  1'b0, 32'h0,        1'b0, 1'b0, 9'd2, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd1,  1'b0, 32'h22222222, 1'b0, 1'b0, 9'd2, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b1, 8'd0,  1'b0, 32'h11111111, 1'b0, 1'b0, 9'd2, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd0,  1'b0, 32'h11111111, 1'b0, 1'b0, 9'd2, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd0,  1'b0, 32'h11111111, 1'b0, 1'b0, 9'd2, 1'b0, 16'd0));
        do_reset();

        // Reset in the middle of a load, then a one-word reload.
        for (int i = 0; i < 5; i++) begin
            step(mk(1'b1, 32'h30000000 + i, 1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 1'b1, 1'b0, 9'(i), 1'b0, 16'd0));
        end
        load_valid = 1'b1;
        load_data  = 32'h30000005;
        #2 reset = 1'b1;
        #1;
        chk("midload_wordCount", {23'd0, word_count}, 32'd0);
        chk("midload_loadReady", {31'd0, load_ready}, 32'd1);
        chk("midload_datapathReset", {31'd0, datapath_reset}, 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        step(mk(1'b1, 32'h0ABCDEF0, 1'b1, 1'b0, 8'd0, 1'b1, 32'h0,        1'b1, 1'b0, 9'd0, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b1, 8'd0, 1'b0, 32'h0,        1'b1, 1'b0, 9'd1, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd0, 1'b0, 32'h0ABCDEF0, 1'b0, 1'b0, 9'd1, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,        1'b0, 1'b0, 8'd1, 1'b0, 32'h0,        1'b0, 1'b0, 9'd1, 1'b0, 16'd0));
        do_reset();

        // Full memory with no loadLast: 256 words, then READY with loadReady low.
        for (int i = 0; i < 256; i++) begin
            step(mk(1'b1, 32'h04000000 + i, 1'b0, 1'b0, 8'd0, 1'b1, 32'h0, 1'b1, 1'b0, 9'(i), 1'b0, 16'd0));
        end
        step(mk(1'b1, 32'h0,  1'b0, 1'b0, 8'd0,  1'b0, 32'h0,        1'b1, 1'b0, 9'd256, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,  1'b0, 1'b1, 8'd0,  1'b0, 32'h0,        1'b1, 1'b0, 9'd256, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,  1'b0, 1'b0, 8'hFF, 1'b0, 32'h040000FF, 1'b0, 1'b0, 9'd256, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,  1'b0, 1'b0, 8'hFF, 1'b0, 32'h040000FF, 1'b0, 1'b0, 9'd256, 1'b0, 16'd0));
        step(mk(1'b0, 32'h0,  1'b0, 1'b0, 8'h80, 1'b0, 32'h04000080, 1'b0, 1'b0, 9'd256, 1'b0, 16'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
- REQ-001: The block SHALL have parameter MEM_DEPTH, default 256, the number of 32-bit instruction words stored.
- REQ-002: The block SHALL have parameter HALT_OPCODE, default 6'h3F, the instruction[31:26] value that ends a run.
- REQ-003: The block SHALL have parameter DRAIN_CYCLES, default 4, the number of NOP cycles issued after halt detection.
- REQ-004: clock  in  1  is the single clock for the block.
- REQ-005: reset  in  1  is the reset, asynchronous and active-high.
- REQ-006: loadValid  in  1  SHALL indicate that a program word is present on loadData.
- REQ-007: loadData  in  32  SHALL carry the program word.
- REQ-008: loadLast  in  1  SHALL mark the final word of a program; it is qualified by loadValid.
- REQ-009: loadReady  out  1  SHALL indicate that the block accepts a word this cycle.
- REQ-010: start  in  1  SHALL be a run or reload request, sampled on the clock edge.
- REQ-011: pc  in  8  SHALL be the fetch-stage PC from the datapath, counted in word units.
- REQ-012: instruction  out  32  SHALL drive the datapath instruction input.
- REQ-013: datapathReset  out  1  SHALL hold the datapath in reset.
- REQ-014: halted  out  1  SHALL indicate that the program has finished.
- REQ-015: wordCount  out  9  SHALL report the number of words loaded.
- REQ-016: runCycles  out  16  SHALL report the cycles spent executing.

Function
- REQ-017: The state machine SHALL have the states LOAD, READY, RUN, DRAIN and HALT.
- REQ-018: In LOAD, loadReady SHALL equal (wordCount < MEM_DEPTH); a handshake is loadValid & loadReady.
- REQ-019: On a handshake, the block SHALL write mem[wordCount] = loadData and increment wordCount by 1 on the same edge.
- REQ-020: A handshake with loadLast=1, or a handshake that brings wordCount to MEM_DEPTH, SHALL move the state LOAD -> READY.
- REQ-021: loadValid SHALL be ignored in every state other than LOAD, and loadReady SHALL be 0 in those states.
- REQ-022: start SHALL be ignored in LOAD.
- REQ-023: In READY, start=1 SHALL move the state to RUN.
- REQ-024: datapathReset SHALL be 1 in LOAD and READY, and 0 in RUN, DRAIN and HALT.
- REQ-025: In RUN, instruction SHALL be combinational from pc with zero latency, so that the value is valid in the same cycle pc changes.
- REQ-026: In RUN, instruction SHALL be mem[pc] when {1'b0,pc} < wordCount, and 32'h0 (NOP) otherwise.
- REQ-027: In RUN, if the word at mem[pc] has [31:26] == HALT_OPCODE, the block SHALL output 32'h0 for that word, load the drain counter with DRAIN_CYCLES, and move to DRAIN on the next edge.
- REQ-028: In DRAIN, instruction SHALL be 32'h0 and the drain counter SHALL decrement each cycle; the state SHALL move DRAIN -> HALT on the edge where the counter is 1.
- REQ-029: In LOAD, READY and HALT, instruction SHALL be 32'h0.
- REQ-030: halted SHALL be 1 only in HALT.
- REQ-031: In HALT, start=1 SHALL clear wordCount to 0 and move the state to LOAD.
- REQ-032: start SHALL be ignored in RUN and DRAIN.
- REQ-033: Memory contents SHALL persist across reload and reset, but words at or above wordCount SHALL still read as NOP.
- REQ-034: The block SHALL not stall on an unchanging pc; it keeps issuing mem[pc].

Reset
- REQ-035: Reset assertion SHALL asynchronously force state=LOAD, wordCount=0, the drain counter=0 and runCycles=0.
- REQ-036: As a result of reset, the outputs SHALL be loadReady=1, datapathReset=1, halted=0 and instruction=32'h0.
- REQ-037: Reset SHALL not clear memory contents.
- REQ-038: Reset asserted in the middle of a load, run or drain SHALL abandon that operation immediately.
- REQ-039: The first handshake after reset deassertion SHALL write address 0.

Configuration
- REQ-040: With macro CYCLE_COUNTER_EN defined, runCycles SHALL increment by 1 on each clock edge in RUN or DRAIN and saturate at 16'hFFFF.
- REQ-041: With CYCLE_COUNTER_EN defined, runCycles SHALL hold its value in HALT and clear to 0 on the transition READY -> RUN.
- REQ-042: Without CYCLE_COUNTER_EN, runCycles SHALL be constant 16'h0 and no counter register SHALL exist.

Verification
- REQ-043: Load scenario: load 3 words 0x20010005, 0x20020007, 0xFC000000 with loadLast on the third -> wordCount=3 and state READY; datapathReset=1 throughout.
- REQ-044: Run scenario: after the load above, pulse start and drive pc=0,1,2 -> instruction = 0x20010005, 0x20020007, then 0x0 at pc=2.
- REQ-045: Halt scenario: continuing the run above -> 4 NOP cycles in DRAIN, then halted=1 with datapathReset=0; with CYCLE_COUNTER_EN, runCycles=7.
- REQ-046: Full-memory scenario: hold loadValid=1 for 256 words without loadLast -> loadReady drops after word 256 and the state is READY; pc=8'hFF returns the last word.
- REQ-047: Reset scenario: assert reset asynchronously mid-load after 5 words -> wordCount=0 and loadReady=1 immediately; reading pc=0 in RUN after a 1-word reload returns the new word.
- REQ-048: Out-of-range scenario: in RUN with wordCount=2 and pc=8'h10 -> instruction=32'h0; start pulsed in RUN -> no state change.
